// File: rtl/muldiv_sequencer.sv
// EX-stage multiply/divide sequencer: latency-modelled multiply, radix-2 restoring divide.
// stall_req holds the pipe while busy; the result is presented in DONE until pipe_advance.
module muldiv_sequencer #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic        op_mul,
  input  logic        op_div,
  input  logic        op_unsigned,
  input  logic        op_to_gpr,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  input  logic        pipe_advance,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        hi_wen,
  output logic        lo_wen,
  output logic        gpr_result_valid
);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_unsigned;
  logic        r_to_gpr;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_div0;
  logic [31:0] r_divisor;
  logic [31:0] r_rem;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_start;
  logic        w_wr;
  logic        w_neg_q;
  logic        w_neg_r;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;

  assign w_start = ex_valid & (op_mul | op_div) & ~flush;

  // Sign-extending to 64 bits makes one truncated multiply serve both signed and unsigned.
  assign w_a_ext = {{32{src1[31] & ~op_unsigned}}, src1};
  assign w_b_ext = {{32{src2[31] & ~op_unsigned}}, src2};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_abs_a = (~op_unsigned & src1[31]) ? (32'd0 - src1) : src1;
  assign w_abs_b = (~op_unsigned & src2[31]) ? (32'd0 - src2) : src2;

  // r_lo doubles as the dividend shift register; quotient bits enter at the bottom.
  assign w_rem_sh = {r_rem, r_lo[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_divisor};

  assign w_neg_q = ~r_unsigned & (r_sign_a ^ r_sign_b);
  assign w_neg_r = ~r_unsigned & r_sign_a;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_unsigned <= 1'b0;
      r_to_gpr   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div0     <= 1'b0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else if (flush && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_unsigned <= op_unsigned;
            r_to_gpr   <= op_to_gpr;
            r_sign_a   <= src1[31];
            r_sign_b   <= src2[31];
            if (op_mul) begin
              {r_hi, r_lo} <= w_prod;
              r_cnt        <= 5'(MUL_CYCLES - 1);
              r_state      <= S_MUL;
            end else begin
              r_hi      <= src1;
              r_lo      <= w_abs_a;
              r_divisor <= w_abs_b;
              r_div0    <= (src2 == 32'd0);
              r_rem     <= '0;
              r_cnt     <= 5'd31;
              r_state   <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == 5'd0) r_state <= S_DONE;
          else r_cnt <= r_cnt - 5'd1;
        end
        S_DIV: begin
          if (!w_diff[32]) begin
            r_rem <= w_diff[31:0];
            r_lo  <= {r_lo[30:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[31:0];
            r_lo  <= {r_lo[30:0], 1'b0};
          end
          if (r_cnt == 5'd0) r_state <= S_FIX;
          else r_cnt <= r_cnt - 5'd1;
        end
        S_FIX: begin
          // Divide by zero keeps the raw dividend loaded into r_hi at accept.
          if (r_div0) begin
            r_lo <= '1;
          end else begin
            r_lo <= w_neg_q ? (32'd0 - r_lo) : r_lo;
            r_hi <= w_neg_r ? (32'd0 - r_rem) : r_rem;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (pipe_advance) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_req = ((r_state == S_IDLE) & w_start) | (r_state == S_MUL) |
                     (r_state == S_DIV) | (r_state == S_FIX);
  assign done      = (r_state == S_DONE);
  assign w_wr      = done & pipe_advance & ~flush;
  assign hi_wen    = w_wr & ~r_to_gpr;
  assign lo_wen    = w_wr & ~r_to_gpr;
  assign gpr_result_valid = w_wr & r_to_gpr;
  assign res_hi    = r_hi;
  assign res_lo    = r_lo;
endmodule
